// File: rtl/srff_pkg.sv
// Shared types and SR excitation helpers for the SR flop pattern driver.
// Optional build macro: SRFF_FORCE_EXCITE_EN selects explicit set/reset codes
// for every bit instead of the minimal hold-based encoding.
package srff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        FLUSH
    } state_t;

    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RST     = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

    // SR code that moves a flop currently holding q_model to target.
    function automatic logic [1:0] sr_excite(input logic target, input logic q_model);
`ifdef SRFF_FORCE_EXCITE_EN
        // Explicit code every bit; the tracked flop value does not matter.
        return target ? SR_SET : SR_RST;
`else
        if (target == q_model) begin
            return SR_HOLD;
        end
        return target ? SR_SET : SR_RST;
`endif
    endfunction

endpackage

// File: rtl/srff_pattern_driver_readback_chk.sv
// Readback checker: delays each issued target bit by two cycles so it lines up
// with the driven flop's q, then captures the first mismatching bit index.
module srff_readback_chk
    import srff_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             vld_i,
    input  logic             bit_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             q_fb_i,
    output logic             err_o,
    output logic [IDX_W-1:0] err_idx_o
);

    logic             vld_p0, vld_p1;
    logic             exp_bit_p0, exp_bit_p1;
    logic [IDX_W-1:0] idx_p0, idx_p1;
    logic             err_q;
    logic [IDX_W-1:0] err_idx_q;
    logic             mismatch;

    // Stage p1 holds the bit whose effect on q is visible this cycle.
    assign mismatch = vld_p1 & (exp_bit_p1 ^ q_fb_i);

    // Valid bits of the delay line (p0: issued, p1: flop has updated).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= vld_i;
            vld_p1 <= vld_p0;
        end
    end

    // Data of the delay line travels alongside the valid bits.
    always_ff @(posedge clk) begin
        exp_bit_p0 <= bit_i;
        idx_p0     <= idx_i;
        exp_bit_p1 <= exp_bit_p0;
        idx_p1     <= idx_p0;
    end

    // Sticky first-error capture; a new transfer clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else if (clr_i) begin
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else if (mismatch && !err_q) begin
            err_q     <= 1'b1;
            err_idx_q <= idx_p1;
        end
    end

    assign err_o     = err_q;
    assign err_idx_o = err_idx_q;

endmodule

// File: rtl/srff_pattern_driver.sv
// Serial SR flop pattern driver: shifts a WIDTH-bit pattern LSB first onto an
// SR flop's s/r inputs, tracks the flop's value, and checks the q readback.
// Optional build macro: SRFF_FORCE_EXCITE_EN (explicit code for every bit).
module srff_pattern_driver
    import srff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic             q_fb,
    output logic             s,
    output logic             r,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] err_idx
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             qm_q, qm_d;
    logic [1:0]       sr_q, sr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             issue_vld;
    logic             issue_bit;
    logic [IDX_W-1:0] issue_idx;
    logic             clr;

    // Next-state, bit issue and excitation encoding.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        qm_d      = qm_q;
        sr_d      = SR_HOLD;
        busy_d    = busy_q;
        done_d    = 1'b0;
        issue_vld = 1'b0;
        issue_bit = 1'b0;
        issue_idx = cnt_q[IDX_W-1:0];
        clr       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    issue_vld = 1'b1;
                    issue_bit = pattern[0];
                    issue_idx = '0;
                    pat_d     = pattern >> 1;
                    cnt_d     = CNT_W'(1);
                    busy_d    = 1'b1;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d = FLUSH;
                end else begin
                    issue_vld = 1'b1;
                    issue_bit = pat_q[0];
                    pat_d     = pat_q >> 1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            FLUSH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (issue_vld) begin
            sr_d = sr_excite(issue_bit, qm_q);
            qm_d = issue_bit;
        end
    end

    // Control state; the 11 code is squashed to hold as a last line of defence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            qm_q    <= 1'b0;
            sr_q    <= SR_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qm_q    <= qm_d;
            sr_q    <= (sr_d == SR_ILLEGAL) ? SR_HOLD : sr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Pattern shifter and bit counter; only read while a transfer is active.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
        pat_q <= pat_d;
    end

    srff_readback_chk #(
        .IDX_W (IDX_W)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (clr),
        .vld_i     (issue_vld),
        .bit_i     (issue_bit),
        .idx_i     (issue_idx),
        .q_fb_i    (q_fb),
        .err_o     (err),
        .err_idx_o (err_idx)
    );

    assign s    = sr_q[1];
    assign r    = sr_q[0];
    assign busy = busy_q;
    assign done = done_q;

endmodule
